// File: rtl/fetch_pc_unit.sv
// IF-stage next-PC generator: fetch PC register, direct-mapped BTB, and
// mispredict recovery FSM that squashes wrong-path work for a fixed window.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned IDX_BITS     = 6,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        bp_taken_i,
  input  logic        bp_fault_i,
  input  logic        br_mem_i,
  input  logic        br_taken_mem_i,
  input  logic [31:0] pc_mem_i,
  input  logic [31:0] target_mem_i,
  output logic [31:0] pc_if_o,
  output logic        pred_taken_if_o,
  output logic        flush_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 30 - IDX_BITS;

  typedef enum logic {StRun, StRecover} state_t;

  state_t                r_state;
  logic [2:0]            r_rec_cnt;
  logic [31:0]           r_pc;
  logic [31:0]           r_br_cnt;
  logic [31:0]           r_miss_cnt;
  logic [Entries-1:0]    r_valid;
  logic [TagW-1:0]       r_tag    [Entries];
  logic [31:0]           r_target [Entries];

  logic [IDX_BITS-1:0]   w_idx_if;
  logic [TagW-1:0]       w_tag_if;
  logic [IDX_BITS-1:0]   w_idx_mem;
  logic [TagW-1:0]       w_tag_mem;
  logic                  w_run;
  logic                  w_hit;
  logic                  w_fault;
  logic                  w_pred;
  logic                  w_btb_we;
  logic [31:0]           w_pc_next;

  assign w_idx_if  = r_pc[IDX_BITS+1:2];
  assign w_tag_if  = r_pc[31:IDX_BITS+2];
  assign w_idx_mem = pc_mem_i[IDX_BITS+1:2];
  assign w_tag_mem = pc_mem_i[31:IDX_BITS+2];

  assign w_run    = (r_state == StRun);
  // Lookup reads the arrays before this cycle's write lands.
  assign w_hit    = r_valid[w_idx_if] && (r_tag[w_idx_if] == w_tag_if);
  assign w_fault  = w_run & bp_fault_i;
  assign w_pred   = w_hit & bp_taken_i & w_run;
  assign w_btb_we = w_run & br_mem_i & br_taken_mem_i;

  assign pc_if_o         = r_pc;
  assign pred_taken_if_o = w_pred;
  assign flush_o         = w_fault & ~rst;
  assign br_cnt_o        = r_br_cnt;
  assign miss_cnt_o      = r_miss_cnt;

  // Next fetch address: fault redirect > stall hold > BTB target > sequential.
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (w_fault) begin
      w_pc_next = br_taken_mem_i ? target_mem_i : (pc_mem_i + 32'd4);
    end else if (stall_i) begin
      w_pc_next = r_pc;
    end else if (w_pred) begin
      w_pc_next = r_target[w_idx_if];
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Recovery FSM: RECOVER lasts FLUSH_CYCLES cycles after an accepted fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StRun;
      r_rec_cnt <= 3'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (bp_fault_i) begin
            r_state   <= StRecover;
            r_rec_cnt <= 3'(FLUSH_CYCLES - 1);
          end
        end
        StRecover: begin
          if (r_rec_cnt == 3'd0) begin
            r_state <= StRun;
          end else begin
            r_rec_cnt <= r_rec_cnt - 3'd1;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

  // Saturating branch and mispredict counters; wrong-path events are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_run && br_mem_i && (r_br_cnt != 32'hFFFF_FFFF)) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_fault && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // BTB valid bits; only these need clearing on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_btb_we) begin
      r_valid[w_idx_mem] <= 1'b1;
    end
  end

  // BTB tag/target payload, overwritten on taken resolution (aliases evicted).
  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_tag[w_idx_mem]    <= w_tag_mem;
      r_target[w_idx_mem] <= target_mem_i;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, BTB fill/predict, mispredict
// recovery window, aliasing, PC wrap and asynchronous reset during recovery.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        bp_taken_i;
  logic        bp_fault_i;
  logic        br_mem_i;
  logic        br_taken_mem_i;
  logic [31:0] pc_mem_i;
  logic [31:0] target_mem_i;
  logic [31:0] pc_if_o;
  logic        pred_taken_if_o;
  logic        flush_o;
  logic [31:0] br_cnt_o;
  logic [31:0] miss_cnt_o;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .bp_taken_i      (bp_taken_i),
    .bp_fault_i      (bp_fault_i),
    .br_mem_i        (br_mem_i),
    .br_taken_mem_i  (br_taken_mem_i),
    .pc_mem_i        (pc_mem_i),
    .target_mem_i    (target_mem_i),
    .pc_if_o         (pc_if_o),
    .pred_taken_if_o (pred_taken_if_o),
    .flush_o         (flush_o),
    .br_cnt_o        (br_cnt_o),
    .miss_cnt_o      (miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; bp_taken_i = 1'b0; bp_fault_i = 1'b1;
    br_mem_i = 1'b0; br_taken_mem_i = 1'b0; pc_mem_i = '0; target_mem_i = '0;
    #2;
    // 1. Reset values; flush suppressed while rst high even with a fault.
    check("rst_pc", pc_if_o, 32'h3000);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_br_cnt", br_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
    tick(); rst = 1'b0; bp_fault_i = 1'b0; #1;
    check("run_pc0", pc_if_o, 32'h3000);
    tick(); check("run_pc1", pc_if_o, 32'h3004);
    tick(); check("run_pc2", pc_if_o, 32'h3008);
    check("run_flush", {31'd0, flush_o}, 32'd0);
    check("run_br_cnt", br_cnt_o, 32'd0);

    // 2. Fill BTB for 3010 -> 3100, then predict it.
    br_mem_i = 1'b1; br_taken_mem_i = 1'b1; pc_mem_i = 32'h3010; target_mem_i = 32'h3100; #1;
    check("miss_3008", {31'd0, pred_taken_if_o}, 32'd0);
    tick(); br_mem_i = 1'b0; br_taken_mem_i = 1'b0; #1;
    check("fill_pc", pc_if_o, 32'h300C);
    check("fill_br_cnt", br_cnt_o, 32'd1);
    tick(); bp_taken_i = 1'b1; #1;
    check("hit_pc", pc_if_o, 32'h3010);
    check("hit_pred", {31'd0, pred_taken_if_o}, 32'd1);
    tick(); bp_taken_i = 1'b0; #1;
    check("hit_target", pc_if_o, 32'h3100);

    // 3. Mispredict (not taken) with stall: fault wins over stall.
    bp_fault_i = 1'b1; br_mem_i = 1'b1; br_taken_mem_i = 1'b0; pc_mem_i = 32'h3010;
    stall_i = 1'b1; #1;
    check("fault_flush", {31'd0, flush_o}, 32'd1);
    tick();
    check("fault_pc", pc_if_o, 32'h3014);
    check("fault_miss", miss_cnt_o, 32'd1);
    check("fault_br_cnt", br_cnt_o, 32'd2);
    check("rec1_flush", {31'd0, flush_o}, 32'd0);
    tick();
    check("rec2_flush", {31'd0, flush_o}, 32'd0);
    check("rec2_pc_stall", pc_if_o, 32'h3014);
    check("rec2_miss", miss_cnt_o, 32'd1);
    tick(); bp_fault_i = 1'b0; stall_i = 1'b0; #1;
    check("rec3_br_cnt", br_cnt_o, 32'd2);
    tick();
    check("rec_exit_pc", pc_if_o, 32'h3018);
    // Back in RUN: a taken fault is accepted and redirects to its target.
    bp_fault_i = 1'b1; br_mem_i = 1'b1; br_taken_mem_i = 1'b1; pc_mem_i = 32'h3020;
    target_mem_i = 32'h3200; #1;
    check("refault_flush", {31'd0, flush_o}, 32'd1);
    tick(); bp_fault_i = 1'b0; br_mem_i = 1'b0; br_taken_mem_i = 1'b0; #1;
    check("refault_pc", pc_if_o, 32'h3200);
    check("refault_miss", miss_cnt_o, 32'd2);
    check("refault_br_cnt", br_cnt_o, 32'd3);
    tick(); tick(); tick();
    check("rec_adv_pc", pc_if_o, 32'h320C);

    // 4. Alias: 3110 evicts 3010 (same idx); steer fetch back to 3010.
    br_mem_i = 1'b1; br_taken_mem_i = 1'b1; pc_mem_i = 32'h3110; target_mem_i = 32'h3300;
    tick();
    check("alias_br_cnt", br_cnt_o, 32'd4);
    bp_fault_i = 1'b1; br_taken_mem_i = 1'b0; pc_mem_i = 32'h300C; stall_i = 1'b1;
    tick(); bp_fault_i = 1'b0; br_mem_i = 1'b0; #1;
    check("alias_redirect", pc_if_o, 32'h3010);
    check("alias_miss", miss_cnt_o, 32'd3);
    tick(); tick(); tick(); stall_i = 1'b0; bp_taken_i = 1'b1; #1;
    check("alias_hold_pc", pc_if_o, 32'h3010);
    check("alias_pred", {31'd0, pred_taken_if_o}, 32'd0);
    tick(); bp_taken_i = 1'b0; #1;
    check("alias_seq_pc", pc_if_o, 32'h3014);

    // 5. Wrap; fault branch also plants a BTB entry at 3008.
    bp_fault_i = 1'b1; br_mem_i = 1'b1; br_taken_mem_i = 1'b1; pc_mem_i = 32'h3008;
    target_mem_i = 32'hFFFF_FFFC;
    tick(); bp_fault_i = 1'b0; br_mem_i = 1'b0; br_taken_mem_i = 1'b0; #1;
    check("wrap_redirect", pc_if_o, 32'hFFFF_FFFC);
    check("wrap_br_cnt", br_cnt_o, 32'd6);
    tick();
    check("wrap_pc", pc_if_o, 32'h0000_0000);
    check("wrap_miss", miss_cnt_o, 32'd4);

    // 6. Async reset mid-RECOVER.
    bp_fault_i = 1'b1; #2; rst = 1'b1; #1;
    check("arst_pc", pc_if_o, 32'h3000);
    check("arst_flush", {31'd0, flush_o}, 32'd0);
    check("arst_br_cnt", br_cnt_o, 32'd0);
    check("arst_miss", miss_cnt_o, 32'd0);
    tick(); rst = 1'b0; bp_fault_i = 1'b0; #1;
    check("arst_pc_hold", pc_if_o, 32'h3000);
    tick(); tick(); bp_taken_i = 1'b1; #1;
    check("arst_pc_3008", pc_if_o, 32'h3008);
    check("arst_btb_clear", {31'd0, pred_taken_if_o}, 32'd0);
    tick(); bp_taken_i = 1'b0; bp_fault_i = 1'b1; pc_mem_i = 32'h3000; #1;
    check("arst_seq_pc", pc_if_o, 32'h300C);
    check("arst_run_flush", {31'd0, flush_o}, 32'd1);
    tick(); bp_fault_i = 1'b0; #1;
    check("arst_redirect", pc_if_o, 32'h3004);
    check("arst_miss_inc", miss_cnt_o, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
